spi_flash_phy: RTL and testbench
================================

Name: spi_flash_phy

Overview:
- Oversampling SPI mode-0 slave front end that sits directly upstream of the SPI flash emulator.
- Synchronizes the raw sclk/cs_n/mosi pins into clk and deserializes MOSI into bit and byte strobes. The first byte of each transaction is flagged as the command byte.
- Serializes reply bytes supplied by the emulator onto MISO, MSB first.
- Requires clk ≥ 8× sclk.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each input pin (≥2).
- IDLE_TX, 8'hFF, byte driven on MISO when no reply byte is pending.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pin_sclk  in  1  raw SPI clock
- pin_cs_n  in  1  raw chip select, active low
- pin_mosi  in  1  raw MOSI
- pin_miso  out  1  MISO data
- pin_miso_oe  out  1  MISO output enable
- spi_cs  out  1  synchronized chip select, 1 = deselected
- spi_rx_data  out  8  shift register; bits received so far of the current byte sit in the LSBs
- spi_rx_bit  out  3  index (0–7) of the bit just received
- spi_rx_bit_strobe  out  1  one-cycle pulse per received bit
- spi_rx_strobe  out  1  one-cycle pulse when a full byte is in spi_rx_data
- spi_rx_cmd  out  1  pulses together with spi_rx_strobe on the first byte after cs falls
- spi_tx_strobe  in  1  load spi_tx_data as the next reply byte
- spi_tx_data  in  8  reply byte
- rx_abort  out  1  pulse: cs deasserted mid-byte
- tx_underrun  out  1  pulse: byte boundary reached with no reply byte pending

Behaviour:
- Reset values:
  - spi_cs=1, all strobes/pulses=0, spi_rx_data=0, spi_rx_bit=0.
  - pin_miso=1, pin_miso_oe=0.
  - Internal state: bit_cnt=0, first_byte=1, hold_valid=0, tx_shift=IDLE_TX, late_window=0.
- Synchronization:
  - Each pin passes through SYNC_STAGES flops; edges are detected against a previous-sample register.
  - All outputs are registered.
  - Pin change to output pulse latency is SYNC_STAGES+1 clk cycles.
- Deselected (sync cs_n=1):
  - spi_cs=1, bit_cnt=0, first_byte=1, hold_valid=0, late_window=0, pin_miso_oe=0, tx_shift=IDLE_TX.
  - If cs rises while bit_cnt≠0, pulse rx_abort once.
  - Sclk edges while deselected are ignored.
- Selected: spi_cs=0, pin_miso_oe=1.
- Sclk rising edge (receive):
  - rx_shift={rx_shift[6:0],mosi}; spi_rx_bit=bit_cnt; spi_rx_bit_strobe=1; bit_cnt increments mod 8.
  - When bit_cnt was 7: spi_rx_strobe=1, spi_rx_cmd=first_byte, first_byte←0.
  - spi_rx_data updates in the same cycle as the strobes.
- Sclk falling edge (transmit):
  - bit_cnt≠0: pin_miso←tx_shift[6], tx_shift←tx_shift<<1.
  - bit_cnt=0 (byte boundary):
    - If hold_valid: tx_shift←hold, pin_miso←hold[7], hold_valid←0.
    - Else: tx_shift←IDLE_TX, pin_miso←1, pulse tx_underrun, late_window←1.
- Immediately after cs falls:
  - Bit 7 of the first byte is driven from tx_shift (IDLE_TX unless hold_valid).
  - A tx_strobe in that same cycle sets hold and takes effect at the next boundary.
- spi_tx_strobe handling:
  - If late_window=1 and bit_cnt=0 (no rising edge yet in this byte): tx_shift←data and pin_miso←data[7] immediately; late_window←0; hold untouched.
  - Otherwise: hold←data, hold_valid←1. A second strobe before the boundary overwrites hold (last wins).
  - late_window clears on the next sclk rising edge.
- Simultaneous tx_strobe and boundary falling edge: the strobed byte is loaded directly, with no underrun pulse.
- Mid-operation behaviour:
  - Reset overrides everything.
  - A cs rise mid-transaction discards the partial byte and any pending hold.

Optional Feature:
- SPI_PHY_GLITCH_FILTER_EN defined: synchronized sclk must hold a new level for 2 consecutive clk samples before an edge is accepted. Adds 1 cycle of latency (total SYNC_STAGES+2) and rejects 1-cycle sclk glitches.
- Undefined: a single differing sample is an edge; latency is SYNC_STAGES+1.

Test Plan:
- CS low, clock MOSI 0x03,0x12,0x34,0x56 → four rx_strobes with data 03,12,34,56; rx_cmd only on 03; bit_strobe indices 0..7 per byte.
- During byte 0x56, check spi_rx_bit=6 → spi_rx_data[6:0]=0x56>>1=0x2B.
- tx_strobe 0xA5 during byte 3 → MISO reads 0xA5 during byte 4, no tx_underrun.
- No tx_strobe, then tx_strobe 0x3C after the boundary fall but before the first rise → tx_underrun pulse, MISO byte reads 0x3C.
- CS rises after 5 bits → rx_abort pulse, no rx_strobe; next transaction's first byte is flagged rx_cmd.
- Reset asserted mid-byte → all outputs return to reset values next cycle; with SPI_PHY_GLITCH_FILTER_EN, a 1-cycle sclk pulse produces no bit_strobe.

Source files
------------

// File: rtl/spi_flash_phy.sv
// SPI mode-0 slave front end: pin synchronizers, MOSI deserializer and MISO serializer.
// Optional sclk glitch filter enabled by defining SPI_PHY_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module spi_flash_phy #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_TX     = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pin_sclk,
   input  logic       pin_cs_n,
   input  logic       pin_mosi,
   output logic       pin_miso,
   output logic       pin_miso_oe,
   output logic       spi_cs,
   output logic [7:0] spi_rx_data,
   output logic [2:0] spi_rx_bit,
   output logic       spi_rx_bit_strobe,
   output logic       spi_rx_strobe,
   output logic       spi_rx_cmd,
   input  logic       spi_tx_strobe,
   input  logic [7:0] spi_tx_data,
   output logic       rx_abort,
   output logic       tx_underrun
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_lvl;
   logic                   sclk_rise;
   logic                   sclk_fall;

   logic [CNT_W-1:0]  bit_cnt;
   logic              first_byte;
   logic [BYTE_W-1:0] hold;
   logic              hold_valid;
   logic [BYTE_W-1:0] tx_shift;
   logic              late_window;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

`ifdef SPI_PHY_GLITCH_FILTER_EN
   // An edge is accepted only once the new level has been seen on two consecutive samples.
   logic sclk_d1;
   assign sclk_rise = sclk_s & sclk_d1 & ~sclk_lvl;
   assign sclk_fall = ~sclk_s & ~sclk_d1 & sclk_lvl;
`else
   assign sclk_rise = sclk_s & ~sclk_lvl;
   assign sclk_fall = ~sclk_s & sclk_lvl;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync         <= '0;
         cs_sync           <= '1;
         mosi_sync         <= '0;
         sclk_lvl          <= 1'b0;
`ifdef SPI_PHY_GLITCH_FILTER_EN
         sclk_d1           <= 1'b0;
`endif
         bit_cnt           <= '0;
         first_byte        <= 1'b1;
         hold              <= '0;
         hold_valid        <= 1'b0;
         tx_shift          <= IDLE_TX;
         late_window       <= 1'b0;
         pin_miso          <= 1'b1;
         pin_miso_oe       <= 1'b0;
         spi_cs            <= 1'b1;
         spi_rx_data       <= '0;
         spi_rx_bit        <= '0;
         spi_rx_bit_strobe <= 1'b0;
         spi_rx_strobe     <= 1'b0;
         spi_rx_cmd        <= 1'b0;
         rx_abort          <= 1'b0;
         tx_underrun       <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], pin_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], pin_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], pin_mosi};
`ifdef SPI_PHY_GLITCH_FILTER_EN
         sclk_d1   <= sclk_s;
         if (sclk_s == sclk_d1) sclk_lvl <= sclk_s;
`else
         sclk_lvl  <= sclk_s;
`endif

         spi_rx_bit_strobe <= 1'b0;
         spi_rx_strobe     <= 1'b0;
         spi_rx_cmd        <= 1'b0;
         rx_abort          <= 1'b0;
         tx_underrun       <= 1'b0;
         spi_cs            <= cs_s;

         if (cs_s) begin
            // Deselected: discard partial byte and pending reply, park MISO.
            if (bit_cnt != '0) rx_abort <= 1'b1;
            bit_cnt     <= '0;
            first_byte  <= 1'b1;
            hold_valid  <= 1'b0;
            late_window <= 1'b0;
            tx_shift    <= IDLE_TX;
            pin_miso    <= IDLE_TX[7];
            pin_miso_oe <= 1'b0;
         end else begin
            pin_miso_oe <= 1'b1;

            if (sclk_rise) begin
               spi_rx_data       <= {spi_rx_data[6:0], mosi_s};
               spi_rx_bit        <= bit_cnt;
               spi_rx_bit_strobe <= 1'b1;
               bit_cnt           <= CNT_W'(bit_cnt + CNT_W'(1));
               late_window       <= 1'b0;
               if (bit_cnt == CNT_W'(7)) begin
                  spi_rx_strobe <= 1'b1;
                  spi_rx_cmd    <= first_byte;
                  first_byte    <= 1'b0;
               end
            end

            if (sclk_fall && bit_cnt == '0) begin
               // Byte boundary: a same-cycle strobe wins over hold and avoids an underrun.
               if (spi_tx_strobe) begin
                  tx_shift   <= spi_tx_data;
                  pin_miso   <= spi_tx_data[7];
                  hold_valid <= 1'b0;
               end else if (hold_valid) begin
                  tx_shift   <= hold;
                  pin_miso   <= hold[7];
                  hold_valid <= 1'b0;
               end else begin
                  tx_shift    <= IDLE_TX;
                  pin_miso    <= 1'b1;
                  tx_underrun <= 1'b1;
                  late_window <= 1'b1;
               end
            end else begin
               if (sclk_fall) begin
                  pin_miso <= tx_shift[6];
                  tx_shift <= {tx_shift[6:0], 1'b0};
               end
               if (spi_tx_strobe) begin
                  // A late reply can still replace the idle byte before its first bit is sampled.
                  if (late_window && bit_cnt == '0 && !sclk_rise) begin
                     tx_shift    <= spi_tx_data;
                     pin_miso    <= spi_tx_data[7];
                     late_window <= 1'b0;
                  end else begin
                     hold       <= spi_tx_data;
                     hold_valid <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_phy.sv
// Directed bench for spi_flash_phy: bytes, command flag, reply path, underrun, abort, reset.
`timescale 1ns/1ps
module tb_spi_flash_phy;

   localparam int unsigned SYNC = 2;
   localparam int unsigned HALF = 6;
`ifdef SPI_PHY_GLITCH_FILTER_EN
   localparam int unsigned LAT = SYNC + 2;
`else
   localparam int unsigned LAT = SYNC + 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       pin_sclk, pin_cs_n, pin_mosi;
   logic       pin_miso, pin_miso_oe, spi_cs;
   logic [7:0] spi_rx_data;
   logic [2:0] spi_rx_bit;
   logic       spi_rx_bit_strobe, spi_rx_strobe, spi_rx_cmd;
   logic       spi_tx_strobe;
   logic [7:0] spi_tx_data;
   logic       rx_abort, tx_underrun;

   int checks = 0;
   int failures = 0;
   int ucnt = 0;
   int acnt = 0;
   logic [7:0] rxq[$];
   logic       cmdq[$];
   logic [2:0] bitq[$];
   logic [7:0] b6q[$];

   spi_flash_phy #(.SYNC_STAGES(SYNC), .IDLE_TX(8'hFF)) dut (
      .clk(clk), .reset(reset),
      .pin_sclk(pin_sclk), .pin_cs_n(pin_cs_n), .pin_mosi(pin_mosi),
      .pin_miso(pin_miso), .pin_miso_oe(pin_miso_oe), .spi_cs(spi_cs),
      .spi_rx_data(spi_rx_data), .spi_rx_bit(spi_rx_bit),
      .spi_rx_bit_strobe(spi_rx_bit_strobe), .spi_rx_strobe(spi_rx_strobe),
      .spi_rx_cmd(spi_rx_cmd), .spi_tx_strobe(spi_tx_strobe), .spi_tx_data(spi_tx_data),
      .rx_abort(rx_abort), .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (spi_rx_strobe) begin
            rxq.push_back(spi_rx_data);
            cmdq.push_back(spi_rx_cmd);
         end
         if (spi_rx_bit_strobe) bitq.push_back(spi_rx_bit);
         if (spi_rx_bit_strobe && spi_rx_bit == 3'd6) b6q.push_back(spi_rx_data);
         if (tx_underrun) ucnt++;
         if (rx_abort) acnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Master clocks n bits of mo MSB first, sampling MISO at each rising edge.
   task automatic spi_bits(input int n, input logic [7:0] mo, input int sb,
                           input logic [7:0] sd, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < n; i++) begin
         pin_mosi = mo[7-i];
         tick(HALF);
         mi = {mi[6:0], pin_miso};
         pin_sclk = 1'b1;
         if (i == sb) begin
            spi_tx_data   = sd;
            spi_tx_strobe = 1'b1;
            tick(1);
            spi_tx_strobe = 1'b0;
            tick(HALF - 1);
         end else begin
            tick(HALF);
         end
         pin_sclk = 1'b0;
      end
      tick(4);
   endtask

   task automatic tx_load(input logic [7:0] d);
      spi_tx_data   = d;
      spi_tx_strobe = 1'b1;
      tick(1);
      spi_tx_strobe = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cs"}, 32'(spi_cs), 32'd1);
      check({tag, "_oe"}, 32'(pin_miso_oe), 32'd0);
      check({tag, "_miso"}, 32'(pin_miso), 32'd1);
      check({tag, "_rxdata"}, 32'(spi_rx_data), 32'd0);
      check({tag, "_rxbit"}, 32'(spi_rx_bit), 32'd0);
      check({tag, "_pulses"},
            32'({spi_rx_bit_strobe, spi_rx_strobe, spi_rx_cmd, rx_abort, tx_underrun}), 32'd0);
   endtask

   task automatic clear_q();
      rxq.delete(); cmdq.delete(); bitq.delete(); b6q.delete();
   endtask

   logic [7:0] mi;
   int lat;

   initial begin
      reset = 1'b1; pin_sclk = 1'b0; pin_cs_n = 1'b1; pin_mosi = 1'b0;
      spi_tx_strobe = 1'b0; spi_tx_data = 8'h00;
      tick(3);
      check_reset_outputs("rst");
      reset = 1'b0;
      tick(4);

      // Main transaction: command byte, replies, hold, late load, underruns.
      pin_cs_n = 1'b0;
      tick(HALF);
      check("sel_cs", 32'(spi_cs), 32'd0);
      check("sel_oe", 32'(pin_miso_oe), 32'd1);
      spi_bits(8, 8'h03, -1, 8'h00, mi);
      check("miso_b0", 32'(mi), 32'hFF);
      check("underrun_b0", 32'(ucnt), 32'd1);
      spi_bits(8, 8'h12, -1, 8'h00, mi);
      check("miso_b1", 32'(mi), 32'hFF);
      check("underrun_b1", 32'(ucnt), 32'd2);
      spi_bits(8, 8'h34, 3, 8'hA5, mi);
      check("miso_b2", 32'(mi), 32'hFF);
      check("underrun_b2", 32'(ucnt), 32'd2);
      spi_bits(8, 8'h56, -1, 8'h00, mi);
      check("miso_b3", 32'(mi), 32'hA5);
      check("underrun_b3", 32'(ucnt), 32'd3);
      tx_load(8'h3C);
      spi_bits(8, 8'h9A, -1, 8'h00, mi);
      check("miso_late", 32'(mi), 32'h3C);
      check("underrun_late", 32'(ucnt), 32'd4);
      pin_cs_n = 1'b1;
      tick(6);
      check("desel_cs", 32'(spi_cs), 32'd1);
      check("desel_oe", 32'(pin_miso_oe), 32'd0);
      check("no_abort", 32'(acnt), 32'd0);
      check("rx_count", 32'(rxq.size()), 32'd5);
      if (rxq.size() == 5) begin
         check("rx0", 32'(rxq[0]), 32'h03);
         check("rx1", 32'(rxq[1]), 32'h12);
         check("rx2", 32'(rxq[2]), 32'h34);
         check("rx3", 32'(rxq[3]), 32'h56);
         check("rx4", 32'(rxq[4]), 32'h9A);
         check("cmd_flags", 32'({cmdq[0], cmdq[1], cmdq[2], cmdq[3], cmdq[4]}), 32'b10000);
      end
      check("bit_count", 32'(bitq.size()), 32'd40);
      for (int i = 0; i < bitq.size(); i++) check("bit_idx", 32'(bitq[i]), 32'(i % 8));
      check("b6_count", 32'(b6q.size()), 32'd5);
      if (b6q.size() >= 4) begin
         check("partial_b0", 32'(b6q[0][6:0]), 32'h01);
         check("partial_b3", 32'(b6q[3][6:0]), 32'h2B);
      end

      // Latency of first bit, then abort after five bits.
      clear_q();
      pin_cs_n = 1'b0;
      tick(HALF);
      pin_mosi = 1'b1;
      pin_sclk = 1'b1;
      lat = 11;
      for (int c = 1; c <= 10; c++) begin
         tick(1);
         if (spi_rx_bit_strobe) begin
            lat = c;
            break;
         end
      end
      check("latency", 32'(lat), 32'(LAT));
      tick(HALF);
      pin_sclk = 1'b0;
      spi_bits(4, 8'hA0, -1, 8'h00, mi);
      pin_cs_n = 1'b1;
      tick(6);
      check("abort_pulse", 32'(acnt), 32'd1);
      check("abort_no_rx", 32'(rxq.size()), 32'd0);
      check("abort_bits", 32'(bitq.size()), 32'd5);

      // First byte after an abort is a command again.
      pin_cs_n = 1'b0;
      tick(HALF);
      spi_bits(8, 8'h81, -1, 8'h00, mi);
      pin_cs_n = 1'b1;
      tick(6);
      check("post_abort_cnt", 32'(rxq.size()), 32'd1);
      if (rxq.size() == 1) begin
         check("post_abort_rx", 32'(rxq[0]), 32'h81);
         check("post_abort_cmd", 32'(cmdq[0]), 32'd1);
      end
      check("abort_once", 32'(acnt), 32'd1);

      // Reset in the middle of a byte.
      clear_q();
      pin_cs_n = 1'b0;
      tick(HALF);
      spi_bits(3, 8'hE0, -1, 8'h00, mi);
      check("pre_reset_rx", 32'(spi_rx_data[2:0]), 32'd7);
      reset = 1'b1;
      pin_cs_n = 1'b1;
      tick(1);
      check_reset_outputs("midrst");
      tick(2);
      reset = 1'b0;
      tick(4);
      pin_cs_n = 1'b0;
      tick(HALF);
      spi_bits(8, 8'hC3, -1, 8'h00, mi);
      pin_cs_n = 1'b1;
      tick(6);
      check("post_reset_cnt", 32'(rxq.size()), 32'd1);
      if (rxq.size() == 1) begin
         check("post_reset_rx", 32'(rxq[0]), 32'hC3);
         check("post_reset_cmd", 32'(cmdq[0]), 32'd1);
      end
      check("post_reset_abort", 32'(acnt), 32'd1);

`ifdef SPI_PHY_GLITCH_FILTER_EN
      // A single-cycle sclk pulse must be rejected.
      clear_q();
      pin_cs_n = 1'b0;
      tick(HALF);
      pin_sclk = 1'b1;
      tick(1);
      pin_sclk = 1'b0;
      tick(8);
      check("glitch_bits", 32'(bitq.size()), 32'd0);
      pin_cs_n = 1'b1;
      tick(6);
      check("glitch_abort", 32'(acnt), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
